store_buffer: RTL and testbench

// Write-direction counterpart of the load path: moves a block of words from on-chip SRAM to DRAM over the AXI write channels (AW/W/B).

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/store_skid_fifo.sv | 63 ++++++
 rtl/store_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_store_buffer.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and AXI constants for the store (SRAM -> DRAM) buffer.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Largest legal AXI size for a 32-bit data path (4 bytes/beat).
  localparam logic [2:0] SIZE_MAX    = 3'd2;

endpackage

// File: rtl/store_skid_fifo.sv
// Two-entry FIFO; entry 0 is always the head so the output is a plain register.
module store_skid_fifo #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] ent0_q;
  logic [DATA_W-1:0] ent1_q;
  logic [1:0]        count_q;
  logic              do_pop;
  logic              do_push;

  // Qualify requests: never pop when empty, never overwrite when full.
  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
  end

  // Shift-register storage: pops move entry 1 down to the head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= push_data_i;
          else                 ent1_q <= push_data_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_q <= push_data_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = ent0_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer: streams a block of SRAM words to DRAM as one AXI INCR write
// burst, with a bounded whole-burst re-send on an error response.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DADDR_W   = 12,
  parameter int unsigned SADDR_W   = 8,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned MAX_RETRY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  // controller command
  input  logic                ctrl_store_vld,
  output logic                ctrl_store_rdy,
  input  logic [ID_W-1:0]     ctrl_store_id,
  input  logic [DADDR_W-1:0]  ctrl_store_dram_addr,
  input  logic [LEN_W-1:0]    ctrl_store_len,
  input  logic [2:0]          ctrl_store_size,
  input  logic [SADDR_W-1:0]  ctrl_store_st_addr,
  input  logic [1:0]          ctrl_store_sram_type,
  output logic                store_done,
  output logic                store_err,
  // SRAM read port
  output logic                store_sram_vld,
  output logic [SADDR_W-1:0]  store_sram_addr,
  output logic [1:0]          store_sram_type,
  input  logic [DATA_W-1:0]   sram_store_dout,
  // AXI AW
  output logic [ID_W-1:0]     store_axi_awid,
  output logic [DADDR_W-1:0]  store_axi_awaddr,
  output logic [LEN_W-1:0]    store_axi_awlen,
  output logic [2:0]          store_axi_awsize,
  output logic [1:0]          store_axi_awburst,
  output logic                store_axi_awvld,
  input  logic                store_axi_awrdy,
  // AXI W
  output logic [DATA_W-1:0]   store_axi_wdata,
  output logic [DATA_W/8-1:0] store_axi_wstrb,
  output logic                store_axi_wlast,
  output logic                store_axi_wvld,
  input  logic                store_axi_wrdy,
  // AXI B
  input  logic [ID_W-1:0]     store_axi_bid,
  input  logic [1:0]          store_axi_bresp,
  input  logic                store_axi_bvld,
  output logic                store_axi_brdy
);

  localparam int unsigned CNT_W   = LEN_W + 1;
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_e               state_q;
  logic                 rdy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 awvld_q;
  logic                 brdy_q;
  logic [ID_W-1:0]      awid_q;
  logic [DADDR_W-1:0]   awaddr_q;
  logic [LEN_W-1:0]     awlen_q;
  logic [2:0]           awsize_q;
  logic [1:0]           awburst_q;
  logic [SADDR_W-1:0]   st_addr_q;
  logic [1:0]           sram_type_q;
  logic                 sram_vld_q;
  logic [SADDR_W-1:0]   sram_addr_q;
  logic                 pend_q;
  logic [CNT_W-1:0]     rd_cnt_q;
  logic [CNT_W-1:0]     beat_cnt_q;
  logic [RETRY_W-1:0]   retry_cnt_q;

  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_hs;
  logic                 wlast_c;
  logic                 rd_ok;
  logic                 occ_ok;
  logic                 rd_issue;
  logic [1:0]           count_d;
  logic [SADDR_W-1:0]   sram_addr_d;

  logic [DATA_W-1:0]    fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [1:0]           fifo_count;

  store_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .push_i      (pend_q),
    .push_data_i (sram_store_dout),
    .pop_i       (w_hs),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Handshakes and SRAM read pacing: a read is launched only if its data is
  // guaranteed a FIFO slot when it lands two cycles later.
  always_comb begin
    aw_hs       = awvld_q && store_axi_awrdy;
    w_hs        = !fifo_empty && store_axi_wrdy;
    b_hs        = brdy_q && store_axi_bvld;
    wlast_c     = (beat_cnt_q == CNT_W'(awlen_q));
    count_d     = fifo_count + 2'(pend_q) - 2'(w_hs);
    rd_ok       = (rd_cnt_q <= CNT_W'(awlen_q));
    occ_ok      = ((3'(count_d) + 3'(sram_vld_q)) < 3'd2) && !(fifo_full && !w_hs);
    rd_issue    = (((state_q == ST_AW) && aw_hs) || (state_q == ST_DATA)) && rd_ok && occ_ok;
    sram_addr_d = (rd_cnt_q == '0) ? st_addr_q : SADDR_W'(sram_addr_q + 1'b1);
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      awvld_q     <= 1'b0;
      brdy_q      <= 1'b0;
      awid_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      awburst_q   <= '0;
      st_addr_q   <= '0;
      sram_type_q <= '0;
      sram_vld_q  <= 1'b0;
      sram_addr_q <= '0;
      pend_q      <= 1'b0;
      rd_cnt_q    <= '0;
      beat_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sram_vld_q <= rd_issue;
      pend_q     <= sram_vld_q;
      if (rd_issue) begin
        sram_addr_q <= sram_addr_d;
        rd_cnt_q    <= rd_cnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (ctrl_store_vld && rdy_q) begin
            awid_q      <= ctrl_store_id;
            awaddr_q    <= ctrl_store_dram_addr;
            awlen_q     <= ctrl_store_len;
            awsize_q    <= ctrl_store_size;
            awburst_q   <= BURST_INCR;
            st_addr_q   <= ctrl_store_st_addr;
            sram_type_q <= ctrl_store_sram_type;
            sram_addr_q <= ctrl_store_st_addr;
            retry_cnt_q <= '0;
            beat_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            if (ctrl_store_size > SIZE_MAX) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              rdy_q   <= 1'b0;
              awvld_q <= 1'b1;
              state_q <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            awvld_q <= 1'b0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (wlast_c) begin
              brdy_q  <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          // Responses tagged with a foreign ID are accepted and dropped.
          if (b_hs && (store_axi_bid == awid_q)) begin
            brdy_q <= 1'b0;
            if (store_axi_bresp == RESP_OKAY) begin
              done_q  <= 1'b1;
              rdy_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
              retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
              beat_cnt_q  <= '0;
              rd_cnt_q    <= '0;
              sram_addr_q <= st_addr_q;
              awvld_q     <= 1'b1;
              state_q     <= ST_AW;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdy_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ctrl_store_rdy    = rdy_q;
  assign store_done        = done_q;
  assign store_err         = err_q;
  assign store_sram_vld    = sram_vld_q;
  assign store_sram_addr   = sram_addr_q;
  assign store_sram_type   = sram_type_q;
  assign store_axi_awid    = awid_q;
  assign store_axi_awaddr  = awaddr_q;
  assign store_axi_awlen   = awlen_q;
  assign store_axi_awsize  = awsize_q;
  assign store_axi_awburst = awburst_q;
  assign store_axi_awvld   = awvld_q;
  assign store_axi_wdata   = fifo_head;
  assign store_axi_wstrb   = '1;
  assign store_axi_wlast   = !fifo_empty && wlast_c;
  assign store_axi_wvld    = !fifo_empty;
  assign store_axi_brdy    = brdy_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed commands push expectations,
// a negedge monitor pops and compares on every DUT handshake.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ctrl_store_vld;
  logic        ctrl_store_rdy;
  logic [7:0]  ctrl_store_id;
  logic [11:0] ctrl_store_dram_addr;
  logic [7:0]  ctrl_store_len;
  logic [2:0]  ctrl_store_size;
  logic [7:0]  ctrl_store_st_addr;
  logic [1:0]  ctrl_store_sram_type;
  logic        store_done;
  logic        store_err;
  logic        store_sram_vld;
  logic [7:0]  store_sram_addr;
  logic [1:0]  store_sram_type;
  logic [31:0] sram_store_dout;
  logic [7:0]  store_axi_awid;
  logic [11:0] store_axi_awaddr;
  logic [7:0]  store_axi_awlen;
  logic [2:0]  store_axi_awsize;
  logic [1:0]  store_axi_awburst;
  logic        store_axi_awvld;
  logic        store_axi_awrdy;
  logic [31:0] store_axi_wdata;
  logic [3:0]  store_axi_wstrb;
  logic        store_axi_wlast;
  logic        store_axi_wvld;
  logic        store_axi_wrdy;
  logic [7:0]  store_axi_bid;
  logic [1:0]  store_axi_bresp;
  logic        store_axi_bvld;
  logic        store_axi_brdy;

  store_buffer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ctrl_store_vld       (ctrl_store_vld),
    .ctrl_store_rdy       (ctrl_store_rdy),
    .ctrl_store_id        (ctrl_store_id),
    .ctrl_store_dram_addr (ctrl_store_dram_addr),
    .ctrl_store_len       (ctrl_store_len),
    .ctrl_store_size      (ctrl_store_size),
    .ctrl_store_st_addr   (ctrl_store_st_addr),
    .ctrl_store_sram_type (ctrl_store_sram_type),
    .store_done           (store_done),
    .store_err            (store_err),
    .store_sram_vld       (store_sram_vld),
    .store_sram_addr      (store_sram_addr),
    .store_sram_type      (store_sram_type),
    .sram_store_dout      (sram_store_dout),
    .store_axi_awid       (store_axi_awid),
    .store_axi_awaddr     (store_axi_awaddr),
    .store_axi_awlen      (store_axi_awlen),
    .store_axi_awsize     (store_axi_awsize),
    .store_axi_awburst    (store_axi_awburst),
    .store_axi_awvld      (store_axi_awvld),
    .store_axi_awrdy      (store_axi_awrdy),
    .store_axi_wdata      (store_axi_wdata),
    .store_axi_wstrb      (store_axi_wstrb),
    .store_axi_wlast      (store_axi_wlast),
    .store_axi_wvld       (store_axi_wvld),
    .store_axi_wrdy       (store_axi_wrdy),
    .store_axi_bid        (store_axi_bid),
    .store_axi_bresp      (store_axi_bresp),
    .store_axi_bvld       (store_axi_bvld),
    .store_axi_brdy       (store_axi_brdy)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [11:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_t;

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  logic [7:0] exp_rd[$];
  logic       exp_done[$];

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         wlast_cnt = 0;
  int         aw_cycles = 0;
  int         wr_mode = 0;
  logic [1:0] exp_type = 2'd0;

  logic [31:0] mem [256];
  logic        hold_pend = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  // Word stored at SRAM address a, e.g. a=8'h10 -> 32'hA510EF3C.
  function automatic logic [31:0] sram_val(input logic [7:0] a);
    return {8'hA5, a, ~a, 8'h3C};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (no expected event)", name);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // SRAM read port model: one-cycle read latency.
  initial for (int i = 0; i < 256; i++) mem[i] = sram_val(8'(i));
  always @(posedge clk) begin
    if (store_sram_vld) sram_store_dout <= mem[store_sram_addr];
  end

  // W-channel ready pattern: 0 = always ready, 1 = toggle, other = held low.
  initial begin
    store_axi_wrdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (wr_mode)
        0:       store_axi_wrdy = 1'b1;
        1:       store_axi_wrdy = ~store_axi_wrdy;
        default: store_axi_wrdy = 1'b0;
      endcase
    end
  end

  // Monitor: pop and compare on each handshake / pulse.
  always @(negedge clk) begin
    aw_t e;
    w_t  w;
    logic [7:0] ra;
    logic de;
    if (!rst_n) begin
      if (store_axi_awvld) aw_cycles++;
      if (store_axi_awvld && store_axi_awrdy) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else begin
          e = exp_aw.pop_front();
          check("awid", 64'(store_axi_awid), 64'(e.id));
          check("awaddr", 64'(store_axi_awaddr), 64'(e.addr));
          check("awlen", 64'(store_axi_awlen), 64'(e.len));
          check("awsize", 64'(store_axi_awsize), 64'(e.size));
          check("awburst", 64'(store_axi_awburst), 64'(BURST_INCR));
        end
      end
      if (hold_pend && store_axi_wvld) begin
        check("w_hold_data", 64'(store_axi_wdata), 64'(held_data));
        check("w_hold_last", 64'(store_axi_wlast), 64'(held_last));
      end
      hold_pend = store_axi_wvld && !store_axi_wrdy;
      held_data = store_axi_wdata;
      held_last = store_axi_wlast;
      if (store_axi_wvld && store_axi_wrdy) begin
        if (store_axi_wlast) wlast_cnt++;
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin
          w = exp_w.pop_front();
          check("wdata", 64'(store_axi_wdata), 64'(w.data));
          check("wlast", 64'(store_axi_wlast), 64'(w.last));
          check("wstrb", 64'(store_axi_wstrb), 64'(4'hF));
        end
      end
      if (store_sram_vld) begin
        if (exp_rd.size() == 0) fail_now("sram_rd_unexpected");
        else begin
          ra = exp_rd.pop_front();
          check("sram_addr", 64'(store_sram_addr), 64'(ra));
          check("sram_type", 64'(store_sram_type), 64'(exp_type));
        end
      end
      if (store_done) begin
        done_cnt++;
        if (exp_done.size() == 0) fail_now("done_unexpected");
        else begin
          de = exp_done.pop_front();
          check("store_err", 64'(store_err), 64'(de));
        end
      end
    end
  end

  task automatic expect_burst(input logic [7:0] id, input logic [11:0] addr,
                              input logic [7:0] len, input logic [7:0] st);
    logic [7:0] a;
    exp_aw.push_back('{id: id, addr: addr, len: len, size: 3'd2});
    for (int i = 0; i <= int'(len); i++) begin
      a = st + 8'(i);
      exp_w.push_back('{data: sram_val(a), last: (i == int'(len))});
      exp_rd.push_back(a);
    end
  endtask

  task automatic issue(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [7:0] st, input logic [1:0] typ);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    ctrl_store_vld       = 1'b1;
    ctrl_store_id        = id;
    ctrl_store_dram_addr = addr;
    ctrl_store_len       = len;
    ctrl_store_size      = size;
    ctrl_store_st_addr   = st;
    ctrl_store_sram_type = typ;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ctrl_store_rdy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) fail_now("cmd_accept_timeout");
    @(posedge clk);
    #1;
    ctrl_store_vld = 1'b0;
  endtask

  task automatic wait_wlast(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (wlast_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wlast_timeout");
  endtask

  task automatic send_b(input logic [7:0] bid, input logic [1:0] resp);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    store_axi_bvld  = 1'b1;
    store_axi_bid   = bid;
    store_axi_bresp = resp;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (store_axi_brdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("brdy_timeout");
    @(posedge clk);
    #1;
    store_axi_bvld = 1'b0;
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("done_timeout");
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"},    64'(ctrl_store_rdy), 64'd1);
    check({tag, "_awvld"},  64'(store_axi_awvld), 64'd0);
    check({tag, "_wvld"},   64'(store_axi_wvld), 64'd0);
    check({tag, "_wlast"},  64'(store_axi_wlast), 64'd0);
    check({tag, "_brdy"},   64'(store_axi_brdy), 64'd0);
    check({tag, "_done"},   64'(store_done), 64'd0);
    check({tag, "_sramvld"}, 64'(store_sram_vld), 64'd0);
  endtask

  initial begin
    int wl;
    int dn;
    int aw_before;
    bit ok;
    wl = 0;
    dn = 0;
    rst_n = 1'b1;
    ctrl_store_vld = 1'b0;
    ctrl_store_id = '0;
    ctrl_store_dram_addr = '0;
    ctrl_store_len = '0;
    ctrl_store_size = '0;
    ctrl_store_st_addr = '0;
    ctrl_store_sram_type = '0;
    store_axi_awrdy = 1'b1;
    store_axi_bid = '0;
    store_axi_bresp = '0;
    store_axi_bvld = 1'b0;
    sram_store_dout = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_awaddr", 64'(store_axi_awaddr), 64'd0);
    check("reset_awburst", 64'(store_axi_awburst), 64'd0);
    check("reset_err", 64'(store_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;

    // Basic 4-beat burst, all ready
    exp_type = 2'd1;
    expect_burst(8'h11, 12'h100, 8'd3, 8'h10);
    exp_done.push_back(1'b0);
    issue(8'h11, 12'h100, 8'd3, 3'd2, 8'h10, 2'd1);
    wl++; wait_wlast(wl);
    send_b(8'h11, RESP_OKAY);
    dn++; wait_done(dn);

    // Same burst with wrdy toggling
    wr_mode = 1;
    expect_burst(8'h22, 12'h100, 8'd3, 8'h10);
    exp_done.push_back(1'b0);
    issue(8'h22, 12'h100, 8'd3, 3'd2, 8'h10, 2'd1);
    wl++; wait_wlast(wl);
    send_b(8'h22, RESP_OKAY);
    dn++; wait_done(dn);
    wr_mode = 0;

    // SRAM address wrap FE,FF,00,01
    exp_type = 2'd2;
    expect_burst(8'h33, 12'h200, 8'd3, 8'hFE);
    exp_done.push_back(1'b0);
    issue(8'h33, 12'h200, 8'd3, 3'd2, 8'hFE, 2'd2);
    wl++; wait_wlast(wl);
    send_b(8'h33, RESP_OKAY);
    dn++; wait_done(dn);

    // Foreign bid ignored, SLVERR then OKAY: burst re-sent, success
    exp_type = 2'd0;
    expect_burst(8'h44, 12'h040, 8'd2, 8'h40);
    expect_burst(8'h44, 12'h040, 8'd2, 8'h40);
    exp_done.push_back(1'b0);
    issue(8'h44, 12'h040, 8'd2, 3'd2, 8'h40, 2'd0);
    wl++; wait_wlast(wl);
    send_b(8'h99, RESP_OKAY);
    send_b(8'h44, RESP_SLVERR);
    wl++; wait_wlast(wl);
    send_b(8'h44, RESP_OKAY);
    dn++; wait_done(dn);

    // Two error responses: retry exhausted -> err
    expect_burst(8'h55, 12'h0A0, 8'd1, 8'h60);
    expect_burst(8'h55, 12'h0A0, 8'd1, 8'h60);
    exp_done.push_back(1'b1);
    issue(8'h55, 12'h0A0, 8'd1, 3'd2, 8'h60, 2'd0);
    wl++; wait_wlast(wl);
    send_b(8'h55, RESP_SLVERR);
    wl++; wait_wlast(wl);
    send_b(8'h55, RESP_DECERR);
    dn++; wait_done(dn);

    // Illegal size: immediate error, no AW
    aw_before = aw_cycles;
    exp_done.push_back(1'b1);
    issue(8'h66, 12'h300, 8'd3, 3'd3, 8'h50, 2'd0);
    dn++; wait_done(dn);
    repeat (5) @(negedge clk);
    check("size3_no_awvld", 64'(aw_cycles - aw_before), 64'd0);

    // Reset mid-DATA with a B response pending
    exp_type = 2'd2;
    wr_mode = 2;
    expect_burst(8'h77, 12'h400, 8'd7, 8'h80);
    issue(8'h77, 12'h400, 8'd7, 3'd2, 8'h80, 2'd2);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (store_axi_wvld) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wvld_timeout");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    store_axi_bvld = 1'b1;
    store_axi_bid  = 8'h77;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midrst");
    exp_aw.delete();
    exp_w.delete();
    exp_rd.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    store_axi_bvld = 1'b0;
    wr_mode = 0;

    // Fresh command after reset completes normally
    exp_type = 2'd3;
    expect_burst(8'h78, 12'h500, 8'd1, 8'h20);
    exp_done.push_back(1'b0);
    issue(8'h78, 12'h500, 8'd1, 3'd2, 8'h20, 2'd3);
    wl++; wait_wlast(wl);
    send_b(8'h78, RESP_OKAY);
    dn++; wait_done(dn);

    repeat (5) @(negedge clk);
    check("left_aw", 64'(exp_aw.size()), 64'd0);
    check("left_w", 64'(exp_w.size()), 64'd0);
    check("left_rd", 64'(exp_rd.size()), 64'd0);
    check("left_done", 64'(exp_done.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'(dn));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
